// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants and helpers shared by the VGA sync generator.
package vga_timing_pkg;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int DEF_HS_START  = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int DEF_HS_END    = DEF_HS_START + DEF_H_SYNC;
  localparam int DEF_VS_START  = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int DEF_VS_END    = DEF_VS_START + DEF_V_SYNC;
  localparam int COLOR_W       = 3;
  // A divide-by-one counter still needs one bit to exist.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: pixel-coordinate link to the painter plus the monitor-facing sync/colour pins.
interface vga_sync_gen_if import vga_timing_pkg::*;;
  logic [COLOR_W-1:0] iColorRGB;
  logic [10:0]        pixelX;
  logic [9:0]         pixelY;
  logic               oPixelTick;
  logic               oVideoOn;
  logic               oHSync;
  logic               oVSync;
  logic [COLOR_W-1:0] oRGB;
  logic               oFrameStart;
  modport master (input iColorRGB, output pixelX, pixelY, oPixelTick, oVideoOn, oHSync, oVSync, oRGB, oFrameStart);
  modport slave  (output iColorRGB, input pixelX, pixelY, oPixelTick, oVideoOn, oHSync, oVSync, oRGB, oFrameStart);
endinterface

// File: rtl/vga_pixel_tick.sv
// vga_pixel_tick: divides clk by CLK_DIV, pulsing tick on the last clk of each pixel period.
module vga_pixel_tick import vga_timing_pkg::*; #(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic iRst_n,
  output logic tick
);
  localparam int W = cnt_w(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
  logic [W-1:0] cnt, nxt;
  always_comb nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
  // tick is registered from the next count so it stays low while held in reset.
  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= nxt;
      tick <= (nxt == LAST);
    end
  end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster counters, region decode and one-pixel-latency output stage.
module vga_sync_gen import vga_timing_pkg::*; #(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int CLK_DIV   = DEF_CLK_DIV
) (
  input  logic           clk,
  input  logic           iRst_n,
  vga_sync_gen_if.master vga
);
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam logic [10:0] X_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] X_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] X_HS0  = 11'(HS_START);
  localparam logic [10:0] X_HS1  = 11'(HS_END);
  localparam logic [9:0]  Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  Y_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0]  Y_VS0  = 10'(VS_START);
  localparam logic [9:0]  Y_VS1  = 10'(VS_END);
  logic               tick, x_last, y_last, hs_raw, vs_raw, vis_raw;
  logic [10:0]        x;
  logic [9:0]         y;
  logic               hs, vs, vid, fs;
  logic [COLOR_W-1:0] rgb;
  vga_pixel_tick #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .iRst_n(iRst_n), .tick(tick));
  always_comb begin
    x_last  = (x == X_LAST);
    y_last  = (y == Y_LAST);
    hs_raw  = (x >= X_HS0) && (x < X_HS1);
    vs_raw  = (y >= Y_VS0) && (y < Y_VS1);
    vis_raw = (x < X_VIS) && (y < Y_VIS);
  end
  // Pins take the decode of the pixel being left, so they trail the counters by one pixel.
  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      x   <= '0;
      y   <= '0;
      hs  <= 1'b1;
      vs  <= 1'b1;
      vid <= 1'b0;
      rgb <= '0;
      fs  <= 1'b0;
    end else begin
      fs <= 1'b0;
      if (tick) begin
        x   <= x_last ? '0 : x + 1'b1;
        y   <= x_last ? (y_last ? '0 : y + 1'b1) : y;
        fs  <= x_last && y_last;
        hs  <= ~hs_raw;
        vs  <= ~vs_raw;
        vid <= vis_raw;
        rgb <= vis_raw ? vga.iColorRGB : '0;
      end
    end
  end
  assign vga.pixelX      = x;
  assign vga.pixelY      = y;
  assign vga.oPixelTick  = tick;
  assign vga.oVideoOn    = vid;
  assign vga.oHSync      = hs;
  assign vga.oVSync      = vs;
  assign vga.oRGB        = rgb;
  assign vga.oFrameStart = fs;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of reset, line/frame timing, blanking and colour alignment.
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  logic [2:0] col_a = 3'd0;
  vga_sync_gen_if vga_a();
  vga_sync_gen_if vga_b();
  vga_sync_gen_if vga_c();
  always #5 clk = ~clk;
  vga_sync_gen dut_a (.clk(clk), .iRst_n(rst_n), .vga(vga_a));
  vga_sync_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3), .V_VISIBLE(6), .V_FRONT(1),
                 .V_SYNC(2), .V_BACK(1), .CLK_DIV(2)) dut_b (.clk(clk), .iRst_n(rst_n), .vga(vga_b));
  vga_sync_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3), .V_VISIBLE(6), .V_FRONT(1),
                 .V_SYNC(2), .V_BACK(1), .CLK_DIV(1)) dut_c (.clk(clk), .iRst_n(rst_n), .vga(vga_c));
  // Painter models: dut_a lights only pixelX=100 one clk after the coordinate; others paint white.
  always_ff @(posedge clk) col_a <= (vga_a.pixelX == 11'd100) ? 3'd1 : 3'd0;
  assign vga_a.iColorRGB = col_a;
  assign vga_b.iColorRGB = 3'd7;
  assign vga_c.iColorRGB = 3'd7;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  int a_tick0, a_x0, a_tick1, a_x1, a_fall_n, a_rise, a_rgb1_n, a_rgb1_t, a_rgb1_x, a_vs_low;
  int a_fall[2];
  int b_fs_n, b_fs_bad, b_vs_low, b_rgb7, b_vid, b_rgb_bad, b_rgb_t;
  int b_fs[2];
  int c_tick0, c_fall_n, c_fs_n, c_fs_bad;
  int c_fall[2];
  int c_fs[2];
  logic a_hs_p, c_hs_p;

  initial begin
    a_fall_n = 0; a_rise = -1; a_rgb1_n = 0; a_rgb1_t = -1; a_rgb1_x = -1; a_vs_low = 0;
    b_fs_n = 0; b_fs_bad = 0; b_vs_low = 0; b_rgb7 = 0; b_vid = 0; b_rgb_bad = 0; b_rgb_t = -1;
    c_tick0 = 0; c_fall_n = 0; c_fs_n = 0; c_fs_bad = 0;
    a_tick0 = 0; a_x0 = 0; a_tick1 = 0; a_x1 = 0;
    repeat (5) @(negedge clk);
    chk("rst_a_x", vga_a.pixelX, 0);
    chk("rst_a_y", vga_a.pixelY, 0);
    chk("rst_a_tick", vga_a.oPixelTick, 0);
    chk("rst_a_hs", vga_a.oHSync, 1);
    chk("rst_a_vs", vga_a.oVSync, 1);
    chk("rst_a_rgb", vga_a.oRGB, 0);
    chk("rst_a_vid", vga_a.oVideoOn, 0);
    chk("rst_a_fs", vga_a.oFrameStart, 0);
    chk("rst_c_tick", vga_c.oPixelTick, 0);
    rst_n = 1'b1;
    a_hs_p = vga_a.oHSync;
    c_hs_p = vga_c.oHSync;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (t == 0) begin a_tick0 = int'(vga_a.oPixelTick); a_x0 = int'(vga_a.pixelX); end
      if (t == 1) begin a_tick1 = int'(vga_a.oPixelTick); a_x1 = int'(vga_a.pixelX); end
      if (a_hs_p && !vga_a.oHSync) begin if (a_fall_n < 2) a_fall[a_fall_n] = t; a_fall_n++; end
      if (!a_hs_p && vga_a.oHSync && a_fall_n == 1 && a_rise < 0) a_rise = t;
      a_hs_p = vga_a.oHSync;
      if (t < 1600 && vga_a.oRGB == 3'd1) begin
        if (a_rgb1_t < 0) begin a_rgb1_t = t; a_rgb1_x = int'(vga_a.pixelX); end
        a_rgb1_n++;
      end
      if (!vga_a.oVSync) a_vs_low++;
      if (vga_b.oFrameStart) begin
        if (b_fs_n < 2) b_fs[b_fs_n] = t;
        b_fs_n++;
        if (vga_b.pixelX != 0 || vga_b.pixelY != 0) b_fs_bad++;
      end
      if (b_fs_n == 1) begin
        if (!vga_b.oVSync) b_vs_low++;
        if (vga_b.oRGB == 3'd7) b_rgb7++;
        if (vga_b.oRGB != 3'd7 && vga_b.oRGB != 3'd0) b_rgb_bad++;
        if (vga_b.oVideoOn) b_vid++;
        if (vga_b.oRGB != 3'd0 && b_rgb_t < 0) b_rgb_t = t;
      end
      if (!vga_c.oPixelTick) c_tick0++;
      if (c_hs_p && !vga_c.oHSync) begin if (c_fall_n < 2) c_fall[c_fall_n] = t; c_fall_n++; end
      c_hs_p = vga_c.oHSync;
      if (vga_c.oFrameStart) begin
        if (c_fs_n < 2) c_fs[c_fs_n] = t;
        c_fs_n++;
        if (vga_c.pixelX != 0 || vga_c.pixelY != 0) c_fs_bad++;
      end
    end
    chk("a_first_tick", a_tick0, 1);
    chk("a_x_at_first_tick", a_x0, 0);
    chk("a_tick_after", a_tick1, 0);
    chk("a_x_after_tick", a_x1, 1);
    chk("a_hs_falls", a_fall_n, 2);
    chk("a_hs_first_fall", a_fall[0], 1313);
    chk("a_hs_period", a_fall[1] - a_fall[0], 1600);
    chk("a_hs_low_width", a_rise - a_fall[0], 192);
    chk("a_vs_low_clks", a_vs_low, 0);
    chk("a_rgb1_start", a_rgb1_t, 201);
    chk("a_rgb1_x", a_rgb1_x, 101);
    chk("a_rgb1_clks", a_rgb1_n, 2);
    chk("b_fs_count", b_fs_n, 9);
    chk("b_fs_first", b_fs[0], 319);
    chk("b_frame_period", b_fs[1] - b_fs[0], 320);
    chk("b_fs_not_origin", b_fs_bad, 0);
    chk("b_vs_low_clks", b_vs_low, 64);
    chk("b_rgb7_clks", b_rgb7, 96);
    chk("b_vid_clks", b_vid, 96);
    chk("b_rgb_bad", b_rgb_bad, 0);
    chk("b_first_rgb", b_rgb_t - b_fs[0], 2);
    chk("c_tick_low", c_tick0, 0);
    chk("c_hs_first_fall", c_fall[0], 11);
    chk("c_hs_period", c_fall[1] - c_fall[0], 16);
    chk("c_fs_first", c_fs[0], 160);
    chk("c_frame_period", c_fs[1] - c_fs[0], 160);
    chk("c_fs_count", c_fs_n, 18);
    chk("c_fs_not_origin", c_fs_bad, 0);
    for (int i = 0; i < 400 && vga_b.oVSync !== 1'b0; i++) @(negedge clk);
    chk("b_vs_low_before_rst", vga_b.oVSync, 0);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_rst_b_x", vga_b.pixelX, 0);
    chk("mid_rst_b_y", vga_b.pixelY, 0);
    chk("mid_rst_b_hs", vga_b.oHSync, 1);
    chk("mid_rst_b_vs", vga_b.oVSync, 1);
    chk("mid_rst_b_rgb", vga_b.oRGB, 0);
    chk("mid_rst_b_vid", vga_b.oVideoOn, 0);
    chk("mid_rst_b_fs", vga_b.oFrameStart, 0);
    chk("mid_rst_a_y", vga_a.pixelY, 0);
    chk("mid_rst_c_tick", vga_c.oPixelTick, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_b_tick", vga_b.oPixelTick, 1);
    chk("rel_b_x", vga_b.pixelX, 0);
    @(negedge clk);
    chk("rel_b_x_next", vga_b.pixelX, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
